// File: rtl/xy_packetizer.sv
// xy_packetizer: turns a {col,row,len} request plus payload words into header/body/tail flits
// for the RESOURCE port of an XY mesh switch, behind a single output flit register.
module xy_packetizer #(
   parameter int COL_ADDR_W = 4,
   parameter int ROW_ADDR_W = 4,
   parameter int DATA_W     = 8,
   parameter int LEN_W      = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  pkt_valid_i,
   output logic                  pkt_ready_o,
   input  logic [COL_ADDR_W-1:0] pkt_col_addr_i,
   input  logic [ROW_ADDR_W-1:0] pkt_row_addr_i,
   input  logic [LEN_W-1:0]      pkt_len_i,
   input  logic                  data_valid_i,
   output logic                  data_ready_o,
   input  logic [DATA_W-1:0]     data_i,
   output logic [DATA_W+1:0]     flit_o,
   output logic                  flit_valid_o,
   input  logic                  flit_ready_i,
   output logic                  busy_o
);
   typedef enum logic [1:0] {IDLE, PAYLOAD, ZTAIL} state_e;
   localparam logic [1:0] ID_HEAD = 2'b01;
   localparam logic [1:0] ID_BODY = 2'b10;
   localparam logic [1:0] ID_TAIL = 2'b11;
   state_e             state_q, state_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic [DATA_W+1:0]  flit_q, flit_d;
   logic               fv_q, fv_d;
   logic               can_load;
   logic [DATA_W-1:0]  hdr;
   assign can_load = !fv_q || flit_ready_i;
   assign hdr      = DATA_W'({pkt_row_addr_i, pkt_col_addr_i});
   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      flit_d       = flit_q;
      fv_d         = fv_q;
      pkt_ready_o  = 1'b0;
      data_ready_o = 1'b0;
      if (fv_q && flit_ready_i) begin
         flit_d = '0;
         fv_d   = 1'b0;
      end
      case (state_q)
         IDLE: begin
            // gated by rst_ni so the request side reads not-ready throughout reset
            pkt_ready_o = can_load && rst_ni;
            if (pkt_valid_i && pkt_ready_o) begin
               flit_d  = {ID_HEAD, hdr};
               fv_d    = 1'b1;
               rem_d   = pkt_len_i;
               state_d = (pkt_len_i != '0) ? PAYLOAD : ZTAIL;
            end
         end
         PAYLOAD: begin
            data_ready_o = can_load;
            if (data_valid_i && can_load) begin
               flit_d  = {(rem_q == LEN_W'(1)) ? ID_TAIL : ID_BODY, data_i};
               fv_d    = 1'b1;
               rem_d   = (rem_q != '0) ? rem_q - LEN_W'(1) : rem_q;
               state_d = (rem_q == LEN_W'(1)) ? IDLE : PAYLOAD;
            end
         end
         ZTAIL: begin
            if (can_load) begin
               flit_d  = {ID_TAIL, {DATA_W{1'b0}}};
               fv_d    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         rem_q   <= '0;
         flit_q  <= '0;
         fv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         flit_q  <= flit_d;
         fv_q    <= fv_d;
      end
   end
   assign flit_o       = flit_q;
   assign flit_valid_o = fv_q;
   assign busy_o       = (state_q != IDLE) || fv_q;
endmodule

// File: doc/xy_packetizer.md
# xy_packetizer

Resource-side network interface that turns a request (destination column/row plus a payload word stream) into the flit sequence the XY-routing mesh switches consume. It emits one header flit carrying the destination address, then body flits, and marks the last payload flit as tail. It sits between a processing element and the RESOURCE input port (port 0) of its local switch, and drives that port under valid/ready flow control.

## Interface
- COL_ADDR_W, 4, destination column address width.
- ROW_ADDR_W, 4, destination row address width.
- DATA_W, 8, flit payload width; must be >= COL_ADDR_W+ROW_ADDR_W.
- LEN_W, 4, payload-length field width; a packet carries 0..2^LEN_W-1 payload words.
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- pkt_valid_i  in  1  packet request valid.
- pkt_ready_o  out  1  request accepted on the edge where valid and ready are both high.
- pkt_col_addr_i  in  COL_ADDR_W  destination column.
- pkt_row_addr_i  in  ROW_ADDR_W  destination row.
- pkt_len_i  in  LEN_W  number of payload words.
- data_valid_i  in  1  payload word valid.
- data_ready_o  out  1  payload word accepted on a valid&ready edge.
- data_i  in  DATA_W  payload word.
- flit_o  out  DATA_W+2  flit, {id[1:0], payload}.
- flit_valid_o  out  1  flit_o is valid.
- flit_ready_i  in  1  downstream switch buffer can take a flit.
- busy_o  out  1  a packet is in progress or a flit is pending.

## Operation
- Flit id encoding: 2'b00 empty, 2'b01 header, 2'b10 body, 2'b11 tail.
- Header payload layout: [COL_ADDR_W-1:0] holds col, [COL_ADDR_W+ROW_ADDR_W-1:COL_ADDR_W] holds row, and the remaining upper bits are 0.
- Output stage: a single flit register. It can load when it is empty (!flit_valid_o) or is being consumed (flit_valid_o && flit_ready_i). When it is consumed and nothing loads, it clears: flit_valid_o=0 and flit_o=0.
- FSM states:
  - IDLE: pkt_ready_o = can-load. On request accept, latch addr/len into rem_q and load the header flit. Next state is PAYLOAD if len>0, otherwise ZTAIL.
  - PAYLOAD: data_ready_o = can-load. On data accept, load {id, data_i}; id is tail if rem_q==1, body otherwise. Decrement rem_q. When rem_q==1 is accepted, go to IDLE.
  - ZTAIL: when can-load, load tail flit 2'b11 with payload 0 and go to IDLE. No data is consumed.
- pkt_ready_o is low outside IDLE; data_ready_o is low outside PAYLOAD.
- No data word is ever dropped or duplicated. flit_o and flit_valid_o stay stable while valid and not ready.
- busy_o = (state != IDLE) || flit_valid_o.
- rem_q is LEN_W wide and never wraps: decrement happens only when rem_q >= 1.
- Reset, including mid-packet: state IDLE, rem_q=0, flit register cleared, all outputs 0. A partial packet is abandoned; the downstream switch is reset in the same domain.

## Timing
- Reset values: pkt_ready_o=0 while rst_ni is low and 1 from the first cycle after release (IDLE, register empty). data_ready_o=0, flit_o=0, flit_valid_o=0, busy_o=0.
- Request accepted at edge k: header is valid from edge k onward (1-cycle latency).
- Payload word accepted at edge m: its flit is valid from edge m.
- Ready paths are combinational from flit_ready_i; valid and data outputs are registered.
- With flit_ready_i held high, a packet of length L occupies L+1 consecutive cycles (L=0: 2 cycles) with no bubbles.
- The next request can be accepted on the same edge the tail is consumed, so back-to-back packets have zero idle cycles.
- A request arriving while busy waits; pkt_ready_o stays low until the FSM returns to IDLE with a loadable register.

## Test plan
- Reset: hold rst_ni=0 with random inputs. Then flit_o=0, flit_valid_o=0, busy_o=0, pkt_ready_o=0, data_ready_o=0. After release, pkt_ready_o=1.
- Basic packet: col=3, row=2, len=3, data 0xA1, 0xB2, 0xC3, flit_ready_i=1. Expect consecutive flits 0x123, 0x2A1, 0x2B2, 0x3C3, then flit_valid_o=0 and busy_o=0.
- Backpressure: same packet with flit_ready_i=0 for 3 cycles while 0x2A1 is presented. Expect flit_o held at 0x2A1, data_ready_o=0 and no extra data consumed; the sequence resumes intact.
- Zero length: col=1, row=0, len=0. Expect flit 0x101 then 0x300, with data_ready_o never asserted.
- Back-to-back: packet (col 3, row 2, len 1, data 0x55) with a second request (col 0, row 1, len 1, data 0x66) already pending. Expect 0x123, 0x355, 0x110, 0x366 on 4 consecutive cycles.
- Reset mid-packet: assert rst_ni=0 after the header of a len=3 packet. Outputs clear immediately (asynchronous). After release a fresh len=1 packet is emitted correctly with no leftover body flits.
